ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 134 +++++++++++++
 tb/tb_ex_muldiv_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative 64-bit unsigned multiply/divide unit for the EX stage.
// One shift-add or restoring-divide step per clock; the pipeline is held via stall.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        valid_out,
  output logic [63:0] result,
  output logic [4:0]  rd_out,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    cnt_q;
  logic [1:0]    op_q;
  logic [63:0]   a_q;
  logic [63:0]   b_q;
  logic [127:0]  prod_q;
  logic [64:0]   rem_q;
  logic [4:0]    rd_q;
  logic [63:0]   result_q;
  logic [4:0]    rd_out_q;

  // Handshake: start is a request sampled only in IDLE with flush low; the
  // request is taken on that edge, and valid_out pulses for one cycle in DONE.
  logic accept;
  logic last_iter;
  logic b_zero;
  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign last_iter = (cnt_q == 7'd63);
  assign b_zero    = (b == 64'd0);

  // Shift-add: add multiplicand into the upper half when the low bit is set, then shift right.
  logic [64:0]  mul_sum;
  logic [127:0] prod_nxt;
  assign mul_sum  = {1'b0, prod_q[127:64]} + (prod_q[0] ? {1'b0, b_q} : 65'd0);
  assign prod_nxt = {mul_sum, prod_q[63:1]};

  // Restoring divide: a_q shifts the dividend out at the top and the quotient in at the bottom.
  logic [64:0] div_shift;
  logic [65:0] div_trial;
  logic        div_fit;
  logic [64:0] rem_nxt;
  logic [63:0] quo_nxt;
  assign div_shift = {rem_q[63:0], a_q[63]};
  assign div_trial = {1'b0, div_shift} - {2'b00, b_q};
  assign div_fit   = ~div_trial[65];
  assign rem_nxt   = div_fit ? div_trial[64:0] : div_shift;
  assign quo_nxt   = {a_q[62:0], div_fit};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (!op[1])     state_d = S_MUL;
        else if (b_zero) state_d = S_DONE;
        else            state_d = S_DIV;
      end
      S_MUL:  if (last_iter) state_d = S_DONE;
      S_DIV:  if (last_iter) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 7'd0;
      op_q     <= 2'd0;
      a_q      <= 64'd0;
      b_q      <= 64'd0;
      prod_q   <= 128'd0;
      rem_q    <= 65'd0;
      rd_q     <= 5'd0;
      result_q <= 64'd0;
      rd_out_q <= 5'd0;
    end else if (accept) begin
      cnt_q  <= 7'd0;
      op_q   <= op;
      a_q    <= a;
      b_q    <= b;
      rd_q   <= rd_in;
      prod_q <= {64'd0, a};
      rem_q  <= 65'd0;
      if (op[1] && b_zero) begin
        result_q <= op[0] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        rd_out_q <= rd_in;
      end
    end else if (state_q == S_MUL) begin
      cnt_q  <= cnt_q + 7'd1;
      prod_q <= prod_nxt;
      if (last_iter && !flush) begin
        result_q <= op_q[0] ? prod_nxt[127:64] : prod_nxt[63:0];
        rd_out_q <= rd_q;
      end
    end else if (state_q == S_DIV) begin
      cnt_q <= cnt_q + 7'd1;
      rem_q <= rem_nxt;
      a_q   <= quo_nxt;
      if (last_iter && !flush) begin
        result_q <= op_q[0] ? rem_nxt[63:0] : quo_nxt;
        rd_out_q <= rd_q;
      end
    end
  end

  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign stall     = busy || accept;
  assign valid_out = (state_q == S_DONE);
  assign result    = result_q;
  assign rd_out    = rd_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed corner cases plus random traffic, all
// checked cycle by cycle against a cycle-count/arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [63:0] a = 64'd0;
  logic [63:0] b = 64'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        flush = 1'b0;
  logic        stall, busy, valid_out;
  logic [63:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  dbg_state;

  ex_muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .rd_in(rd_in), .flush(flush), .stall(stall), .busy(busy),
    .valid_out(valid_out), .result(result), .rd_out(rd_out),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    logic [127:0] p;
    p = {64'd0, x} * {64'd0, y};
    case (o)
      2'd0:    return p[63:0];
      2'd1:    return p[127:64];
      2'd2:    return (y == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
      default: return (y == 64'd0) ? x : x % y;
    endcase
  endfunction

  // m_iter: clock edges still to go before the result appears; m_valid: result cycle.
  int          m_iter  = 0;
  bit          m_valid = 1'b0;
  logic [63:0] m_res   = 64'd0;
  logic [63:0] m_pend  = 64'd0;
  logic [4:0]  m_rd    = 5'd0;
  logic [4:0]  m_prd   = 5'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_iter = 0; m_valid = 1'b0; m_res = 64'd0; m_rd = 5'd0;
    end else if (flush) begin
      m_iter = 0; m_valid = 1'b0;
    end else if (m_valid) begin
      m_valid = 1'b0;
    end else if (m_iter > 0) begin
      m_iter--;
      if (m_iter == 0) begin
        m_valid = 1'b1; m_res = m_pend; m_rd = m_prd;
      end
    end else if (start) begin
      m_pend = ref_result(op, a, b);
      m_prd  = rd_in;
      if (op[1] && b == 64'd0) begin
        m_valid = 1'b1; m_res = m_pend; m_rd = m_prd;
      end else begin
        m_iter = 64;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("valid_out", {63'd0, valid_out}, {63'd0, m_valid});
    check("busy", {63'd0, busy}, {63'd0, (m_iter > 0)});
    check("stall", {63'd0, stall}, {63'd0, (m_iter > 0) || (!m_valid && start && !flush)});
    check("result", result, m_res);
    check("rd_out", {59'd0, rd_out}, {59'd0, m_rd});
  end

  // ---------------- driver tasks ----------------
  // Called just after the accept edge; counts edges until valid_out is seen.
  task automatic wait_check(input logic [63:0] exp_res, input logic [4:0] exp_rd,
                            input int exp_lat, input int pulse_at);
    int  n;
    bit  done;
    n = 0; done = 1'b0;
    while (n < 200 && !done) begin
      @(negedge clk);
      if (valid_out) done = 1'b1;
      else begin
        @(posedge clk);
        n++;
        #1 start = (n == pulse_at);
      end
    end
    start = 1'b0;
    check("latency", 64'(n), 64'(exp_lat));
    check("lit_result", result, exp_res);
    check("lit_rd_out", {59'd0, rd_out}, {59'd0, exp_rd});
  endtask

  task automatic run_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [4:0] rd, input logic [63:0] exp_res, input int exp_lat);
    @(posedge clk);
    #1 start = 1'b1; op = o; a = x; b = y; rd_in = rd; flush = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_check(exp_res, rd, exp_lat, -1);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 255));
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom} >> $urandom_range(0, 63);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int extra;
    #12;
    check("rst_result", result, 64'd0);
    check("rst_rd_out", {59'd0, rd_out}, 64'd0);
    check("rst_valid", {63'd0, valid_out}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    // Release and request on the very first edge: DIVU by zero.
    rst_n = 1'b1;
    start = 1'b1; op = 2'd2; a = 64'd42; b = 64'd0; rd_in = 5'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_check(64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 0, -1);

    run_op(2'd3, 64'd42, 64'd0, 5'd4, 64'd42, 0);
    run_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64);
    run_op(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'h1, 64);
    run_op(2'd2, 64'd100, 64'd7, 5'd9, 64'd14, 64);
    run_op(2'd3, 64'd100, 64'd7, 5'd9, 64'd2, 64);
    run_op(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 64'hFFFF_FFFF_FFFF_FFFE, 64);

    // Flush on the edge completing iteration 30, then an immediate new request.
    @(posedge clk);
    #1 start = 1'b1; op = 2'd0; a = 64'd1234; b = 64'd5678; rd_in = 5'd6;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (29) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    start = 1'b1; op = 2'd0; a = 64'd3; b = 64'd5; rd_in = 5'd7;
    @(posedge clk);
    #1 start = 1'b0;
    check("reaccept_busy", {63'd0, busy}, 64'd1);
    wait_check(64'd15, 5'd7, 64, -1);

    // A start pulse in the middle of a divide must be ignored.
    @(posedge clk);
    #1 start = 1'b1; op = 2'd2; a = 64'd1000; b = 64'd9; rd_in = 5'd12;
    @(posedge clk);
    #1 start = 1'b0;
    wait_check(64'd111, 5'd12, 64, 20);
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid_out) extra++;
    end
    check("single_valid", 64'(extra), 64'd0);

    // Asynchronous reset at iteration 10 clears outputs at once and kills the op.
    @(posedge clk);
    #1 start = 1'b1; op = 2'd1; a = 64'hDEAD_BEEF_0000_1111; b = 64'h1234_5678_9ABC_DEF0; rd_in = 5'd17;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_result", result, 64'd0);
    check("arst_rd_out", {59'd0, rd_out}, 64'd0);
    check("arst_valid", {63'd0, valid_out}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid_out) extra++;
    end
    check("no_valid_after_rst", 64'(extra), 64'd0);

    // Random traffic: overlapping starts, occasional flushes, mixed operand shapes.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'($urandom_range(0, 1));
      op    = 2'($urandom_range(0, 3));
      a     = pick_operand();
      b     = ($urandom_range(0, 7) == 0) ? 64'd0 : pick_operand();
      rd_in = 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    repeat (70) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
